// File: rtl/snake_body_streamer.sv
// Snake segment store: steps the head once per game tick, grows on eat, detects
// wall/self collisions and streams every segment (head first) to the consumer.
module snake_body_streamer #(
  parameter int H_LOGIC_WIDTH = 5,
  parameter int V_LOGIC_WIDTH = 5,
  parameter int H_LOGIC_MAX   = 31,
  parameter int V_LOGIC_MAX   = 23,
  parameter int MAX_LEN       = 64,
  parameter int START_X       = 4,
  parameter int START_Y       = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     move_tick,
  input  logic [1:0]               dir_in,
  input  logic                     is_eat,
  input  logic                     pixel_done,
  output logic                     vld,
  output logic                     vld_start,
  output logic                     vld_t,
  output logic [H_LOGIC_WIDTH-1:0] x_snake_cur,
  output logic [V_LOGIC_WIDTH-1:0] y_snake_cur,
  output logic                     is_end,
  output logic [9:0]               length,
  output logic                     game_over
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IW-1:0]          IDX_ONE = 1;
  localparam logic [H_LOGIC_WIDTH:0] X_ONE   = 1;
  localparam logic [V_LOGIC_WIDTH:0] Y_ONE   = 1;

  typedef enum logic [2:0] {IDLE, MOVE, FRAME, STREAM, DEAD} state_t;

  state_t                   state_q, state_d;
  logic [H_LOGIC_WIDTH-1:0] seg_x_q [MAX_LEN];
  logic [V_LOGIC_WIDTH-1:0] seg_y_q [MAX_LEN];
  logic [1:0]               dir_q, dir_d;
  logic [9:0]               len_q, len_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     grow_q, grow_d;
  logic                     start_q, start_d, vt_q, vt_d;
  logic                     hold_q, hold_d, hit_q, hit_d;
  logic [H_LOGIC_WIDTH:0]   nx;
  logic [V_LOGIC_WIDTH:0]   ny;
  logic                     wall, last, hit_now, shift;

  // One extra bit so that 0-1 wraps to a value above any legal max.
  always_comb begin
    nx = {1'b0, seg_x_q[0]};
    ny = {1'b0, seg_y_q[0]};
    case (dir_q)
      2'd0:    nx = {1'b0, seg_x_q[0]} + X_ONE;
      2'd1:    nx = {1'b0, seg_x_q[0]} - X_ONE;
      2'd2:    ny = {1'b0, seg_y_q[0]} + Y_ONE;
      default: ny = {1'b0, seg_y_q[0]} - Y_ONE;
    endcase
  end

  assign wall    = (nx > (H_LOGIC_WIDTH+1)'(H_LOGIC_MAX)) || (ny > (V_LOGIC_WIDTH+1)'(V_LOGIC_MAX));
  assign last    = (10'(idx_q) == len_q - 10'd1);
  assign hit_now = (idx_q != '0) && (seg_x_q[idx_q] == seg_x_q[0]) && (seg_y_q[idx_q] == seg_y_q[0]);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    len_d   = len_q;
    idx_d   = idx_q;
    grow_d  = grow_q | is_eat;
    start_d = 1'b0;
    vt_d    = 1'b0;
    hold_d  = hold_q;
    hit_d   = hit_q;
    shift   = 1'b0;
    case (state_q)
      IDLE: if (move_tick) begin
        state_d = MOVE;
        if (!(len_q > 10'd1 && dir_in == (dir_q ^ 2'd1))) dir_d = dir_in;
      end
      MOVE: if (wall) begin
        state_d = DEAD;
      end else begin
        shift   = 1'b1;
        state_d = FRAME;
        grow_d  = is_eat;
        if (grow_q && len_q < 10'(MAX_LEN)) len_d = len_q + 10'd1;
      end
      FRAME: begin
        state_d = STREAM;
        idx_d   = '0;
        start_d = 1'b1;
        hold_d  = 1'b0;
        hit_d   = 1'b0;
      end
      STREAM: begin
        if (hit_now) hit_d = 1'b1;
        if (pixel_done) begin
          if (last) begin
            hold_d  = 1'b1;
            state_d = (hit_q || hit_now) ? DEAD : IDLE;
          end else begin
            idx_d = idx_q + IDX_ONE;
            vt_d  = 1'b1;
          end
        end
      end
      DEAD:    state_d = DEAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 2'd0;
      len_q   <= 10'd1;
      idx_q   <= '0;
      grow_q  <= 1'b0;
      start_q <= 1'b0;
      vt_q    <= 1'b0;
      hold_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      grow_q  <= grow_d;
      start_q <= start_d;
      vt_q    <= vt_d;
      hold_q  <= hold_d;
      hit_q   <= hit_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= H_LOGIC_WIDTH'(START_X);
        seg_y_q[k] <= V_LOGIC_WIDTH'(START_Y);
      end
    end else if (shift) begin
      seg_x_q[0] <= nx[H_LOGIC_WIDTH-1:0];
      seg_y_q[0] <= ny[V_LOGIC_WIDTH-1:0];
      for (int k = 1; k < MAX_LEN; k++) begin
        seg_x_q[k] <= seg_x_q[k-1];
        seg_y_q[k] <= seg_y_q[k-1];
      end
    end
  end

  assign vld         = (state_q == FRAME);
  assign vld_start   = start_q;
  assign vld_t       = vt_q;
  assign x_snake_cur = seg_x_q[idx_q];
  assign y_snake_cur = seg_y_q[idx_q];
  // is_end keeps its last value between frames and drops only while vld is up.
  assign is_end      = (state_q == STREAM) ? last : ((state_q == FRAME) ? 1'b0 : hold_q);
  assign length      = len_q;
  assign game_over   = (state_q == DEAD);
endmodule

// File: tb/tb_snake_body_streamer.sv
// Randomized bench for snake_body_streamer: a queue-based snake model predicts each
// frame into a scoreboard that a forked monitor drains as segments are presented.
module tb_snake_body_streamer;
  localparam int MAXL = 8;

  logic       clk = 1'b0, rst = 1'b1, move_tick = 1'b0, is_eat = 1'b0, pixel_done = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic       vld, vld_start, vld_t, is_end, game_over;
  logic [4:0] x_cur, y_cur;
  logic [9:0] length;

  snake_body_streamer #(.MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .dir_in(dir_in), .is_eat(is_eat),
    .pixel_done(pixel_done), .vld(vld), .vld_start(vld_start), .vld_t(vld_t),
    .x_snake_cur(x_cur), .y_snake_cur(y_cur), .is_end(is_end), .length(length),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; bit first; bit last;} seg_t;
  seg_t sb[$];
  int   errors = 0, checks = 0, vld_cnt = 0, vt_cnt = 0, pd_mode = 1;
  int   mx[$], my[$];
  int   m_dir;
  bit   m_grow, m_dead, m_wall;

  // 0: pixel_done low, 1: held high, 2: random
  always @(negedge clk)
    case (pd_mode)
      0:       pixel_done = 1'b0;
      1:       pixel_done = 1'b1;
      default: pixel_done = 1'($urandom_range(0, 1));
    endcase

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    seg_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (vld) vld_cnt++;
        if (vld_t) vt_cnt++;
        if (vld_start || vld_t) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_seg: got (%0d,%0d) expected none", x_cur, y_cur);
          end else begin
            e = sb.pop_front();
            chk("seg_x", x_cur, e.x);
            chk("seg_y", y_cur, e.y);
            chk("seg_is_end", is_end, e.last);
            chk("seg_first", vld_start, e.first);
          end
        end
      end
    end
  endtask

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    mx = {4}; my = {12};
    m_dir = 0; m_grow = 0; m_dead = 0; m_wall = 0;
  endtask

  task automatic model_move(input int d);
    int hx, hy;
    seg_t e;
    if (mx.size() == 1 || d != opposite(m_dir)) m_dir = d;
    hx = mx[0]; hy = my[0];
    case (m_dir)
      0: hx++;
      1: hx--;
      2: hy++;
      default: hy--;
    endcase
    m_wall = (hx < 0 || hx > 31 || hy < 0 || hy > 23);
    if (m_wall) begin
      m_dead = 1;
      return;
    end
    mx.push_front(hx); my.push_front(hy);
    if (!(m_grow && mx.size() <= MAXL)) begin
      void'(mx.pop_back()); void'(my.pop_back());
    end
    m_grow = 0;
    for (int i = 0; i < mx.size(); i++) begin
      e.x = mx[i]; e.y = my[i]; e.first = (i == 0); e.last = (i == mx.size() - 1);
      sb.push_back(e);
      if (i > 0 && mx[i] == mx[0] && my[i] == my[0]) m_dead = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; move_tick = 1'b0; is_eat = 1'b0;
    @(negedge clk);
    chk("rst_vld", vld, 0);
    chk("rst_vld_start", vld_start, 0);
    chk("rst_vld_t", vld_t, 0);
    chk("rst_is_end", is_end, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_x", x_cur, 4);
    chk("rst_y", y_cur, 12);
    chk("rst_length", length, 1);
    sb.delete();
    model_reset();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic eat();
    @(negedge clk); is_eat = 1'b1;
    @(negedge clk); is_eat = 1'b0;
    m_grow = 1;
  endtask

  task automatic step(input int d);
    int v0, t0, n, saved;
    bit was_dead;
    was_dead = m_dead; v0 = vld_cnt; t0 = vt_cnt; m_wall = 0;
    if (!was_dead) model_move(d);
    @(negedge clk); move_tick = 1'b1; dir_in = 2'(d);
    @(negedge clk); move_tick = 1'b0;
    @(negedge clk);
    if (was_dead || m_wall) begin
      chk("dead_no_vld", vld, 0);
      chk("dead_game_over", game_over, 1);
      repeat (4) @(negedge clk);
      chk("dead_vld_cnt", vld_cnt - v0, 0);
    end else begin
      chk("vld_latency", vld, 1);
      @(negedge clk);
      chk("vld_start_latency", vld_start, 1);
      n = 0;
      while (sb.size() != 0 && n < 500) begin
        @(negedge clk); n++;
      end
      if (sb.size() != 0) begin
        chk("frame_timeout_left", sb.size(), 0);
        sb.delete();
      end
      saved = pd_mode; pd_mode = 1;
      repeat (3) @(negedge clk);
      pd_mode = saved;
      chk("frame_vld_cnt", vld_cnt - v0, 1);
      chk("frame_vt_cnt", vt_cnt - t0, mx.size() - 1);
      chk("frame_length", length, mx.size());
      chk("frame_game_over", game_over, m_dead);
      if (!m_dead) chk("is_end_hold", is_end, 1);
    end
  endtask

  initial begin
    logic [4:0] x0, y0;
    bit stable;
    fork monitor(); join_none
    model_reset();
    do_reset();

    // single step, then growth and a held reversal
    pd_mode = 1;
    step(0);
    eat();
    repeat (3) step(0);
    eat();
    step(0);
    step(1);

    // growth saturates at MAXL
    repeat (6) begin eat(); step(0); end
    step(0);
    chk("sat_length", length, MAXL);

    // self collision: length 5 turning a tight square
    do_reset();
    repeat (4) begin eat(); step(0); end
    step(0); step(2); step(1); step(3);
    chk("self_hit_game_over", game_over, 1);
    step(0);

    // wall collision at the right edge
    do_reset();
    repeat (27) step(0);
    chk("at_edge_x", x_cur, 31);
    step(0);
    step(2);
    do_reset();

    // pixel_done withheld mid-stream, then reset mid-stream
    eat(); step(0); eat(); step(0);
    pd_mode = 0;
    @(negedge clk);
    model_move(0);
    @(negedge clk); move_tick = 1'b1; dir_in = 2'd0;
    @(negedge clk); move_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_vld_start", vld_start, 1);
    x0 = x_cur; y0 = y_cur; stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (x_cur !== x0 || y_cur !== y0 || vld_t !== 1'b0) stable = 0;
    end
    chk("hold_stable", stable, 1);
    do_reset();
    pd_mode = 1;

    // random walk with random eats and consumer back-pressure
    pd_mode = 2;
    repeat (60) begin
      if ($urandom_range(0, 2) == 0) eat();
      step(int'($urandom_range(0, 3)));
      if (m_dead) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
